// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: captures decoded control, operands and register
// addresses from ID, with pipeline-wide hold and bubble/flush insertion.
module id_ex_pipeline_reg #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             Stall_i,
  input  logic             Bubble_i,
  input  logic             Flush_i,
  input  logic             ID_Valid_i,
  input  logic             ID_RegWrite_i,
  input  logic             ID_MemtoReg_i,
  input  logic             ID_MemRead_i,
  input  logic             ID_MemWrite_i,
  input  logic             ID_ALUSrc_i,
  input  logic             ID_Branch_i,
  input  logic [1:0]       ID_ALUOp_i,
  input  logic [XLEN-1:0]  ID_PC_i,
  input  logic [XLEN-1:0]  ID_RS1data_i,
  input  logic [XLEN-1:0]  ID_RS2data_i,
  input  logic [XLEN-1:0]  ID_Imm_i,
  input  logic [9:0]       ID_funct_i,
  input  logic [RADDR-1:0] ID_rs1_i,
  input  logic [RADDR-1:0] ID_rs2_i,
  input  logic [RADDR-1:0] ID_Rd_i,
  output logic             EX_Valid_o,
  output logic             EX_RegWrite_o,
  output logic             EX_MemtoReg_o,
  output logic             EX_MemRead_o,
  output logic             EX_MemWrite_o,
  output logic             EX_ALUSrc_o,
  output logic             EX_Branch_o,
  output logic [1:0]       EX_ALUOp_o,
  output logic [XLEN-1:0]  EX_PC_o,
  output logic [XLEN-1:0]  EX_RS1data_o,
  output logic [XLEN-1:0]  EX_RS2data_o,
  output logic [XLEN-1:0]  EX_Imm_o,
  output logic [9:0]       EX_funct_o,
  output logic [RADDR-1:0] EX_rs1_o,
  output logic [RADDR-1:0] EX_rs2_o,
  output logic [RADDR-1:0] EX_Rd_o
);

  localparam int CW = 9;
  localparam int AW = 3 * RADDR;
  localparam int DW = 4 * XLEN + 10;

  logic [CW-1:0] ctrl_in_s, ctrl_d, ctrl_q;
  logic [AW-1:0] addr_in_s, addr_d, addr_q;
  logic [DW-1:0] data_in_s, data_d, data_q;

  assign ctrl_in_s = {ID_Valid_i, ID_RegWrite_i, ID_MemtoReg_i, ID_MemRead_i,
                      ID_MemWrite_i, ID_ALUSrc_i, ID_Branch_i, ID_ALUOp_i};
  assign addr_in_s = {ID_rs1_i, ID_rs2_i, ID_Rd_i};
  assign data_in_s = {ID_PC_i, ID_RS1data_i, ID_RS2data_i, ID_Imm_i, ID_funct_i};

  // Next-state selection: hold, bubble (controls and addresses zeroed), or load.
  always_comb begin
    ctrl_d = ctrl_q;
    addr_d = addr_q;
    data_d = data_q;
    if (Stall_i) begin
      ctrl_d = ctrl_q;
      addr_d = addr_q;
      data_d = data_q;
    end else if (Bubble_i || Flush_i) begin
      // Zero addresses so a bubble never matches forwarding or writes back.
      ctrl_d = {CW{1'b0}};
      addr_d = {AW{1'b0}};
      data_d = data_in_s;
    end else begin
      addr_d = addr_in_s;
      data_d = data_in_s;
      if (ID_Valid_i) begin
        ctrl_d = ctrl_in_s;
      end else begin
        ctrl_d = {CW{1'b0}};
      end
    end
  end

  // Pipeline register with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_q <= {CW{1'b0}};
      addr_q <= {AW{1'b0}};
      data_q <= {DW{1'b0}};
    end else begin
      ctrl_q <= ctrl_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign {EX_Valid_o, EX_RegWrite_o, EX_MemtoReg_o, EX_MemRead_o,
          EX_MemWrite_o, EX_ALUSrc_o, EX_Branch_o, EX_ALUOp_o} = ctrl_q;
  assign {EX_rs1_o, EX_rs2_o, EX_Rd_o} = addr_q;
  assign {EX_PC_o, EX_RS1data_o, EX_RS2data_o, EX_Imm_o, EX_funct_o} = data_q;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Self-checking bench for id_ex_pipeline_reg: directed scenarios plus a
// randomized run compared against a rule-level model of the register.
module tb_id_ex_pipeline_reg;

  typedef struct packed {
    logic        valid, regwrite, memtoreg, memread, memwrite, alusrc, branch;
    logic [1:0]  aluop;
    logic [31:0] pc, rs1data, rs2data, imm;
    logic [9:0]  funct;
    logic [4:0]  rs1, rs2, rd;
  } id_t;

  logic clk_i = 1'b0;
  logic rst_i, Stall_i, Bubble_i, Flush_i;
  logic ID_Valid_i, ID_RegWrite_i, ID_MemtoReg_i, ID_MemRead_i, ID_MemWrite_i, ID_ALUSrc_i, ID_Branch_i;
  logic [1:0]  ID_ALUOp_i;
  logic [31:0] ID_PC_i, ID_RS1data_i, ID_RS2data_i, ID_Imm_i;
  logic [9:0]  ID_funct_i;
  logic [4:0]  ID_rs1_i, ID_rs2_i, ID_Rd_i;
  logic EX_Valid_o, EX_RegWrite_o, EX_MemtoReg_o, EX_MemRead_o, EX_MemWrite_o, EX_ALUSrc_o, EX_Branch_o;
  logic [1:0]  EX_ALUOp_o;
  logic [31:0] EX_PC_o, EX_RS1data_o, EX_RS2data_o, EX_Imm_o;
  logic [9:0]  EX_funct_o;
  logic [4:0]  EX_rs1_o, EX_rs2_o, EX_Rd_o;

  int  cmp_count = 0;
  int  err_count = 0;
  id_t cur;     // what ID currently presents
  id_t exp_s;   // model of EX contents
  bit  exp_dc;  // model contents are a bubble: datapath fields don't-care
  id_t obs;

  always #5 clk_i = ~clk_i;

  id_ex_pipeline_reg #(.XLEN(32), .RADDR(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .Stall_i(Stall_i), .Bubble_i(Bubble_i), .Flush_i(Flush_i),
    .ID_Valid_i(ID_Valid_i), .ID_RegWrite_i(ID_RegWrite_i), .ID_MemtoReg_i(ID_MemtoReg_i),
    .ID_MemRead_i(ID_MemRead_i), .ID_MemWrite_i(ID_MemWrite_i), .ID_ALUSrc_i(ID_ALUSrc_i),
    .ID_Branch_i(ID_Branch_i), .ID_ALUOp_i(ID_ALUOp_i), .ID_PC_i(ID_PC_i),
    .ID_RS1data_i(ID_RS1data_i), .ID_RS2data_i(ID_RS2data_i), .ID_Imm_i(ID_Imm_i),
    .ID_funct_i(ID_funct_i), .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i), .ID_Rd_i(ID_Rd_i),
    .EX_Valid_o(EX_Valid_o), .EX_RegWrite_o(EX_RegWrite_o), .EX_MemtoReg_o(EX_MemtoReg_o),
    .EX_MemRead_o(EX_MemRead_o), .EX_MemWrite_o(EX_MemWrite_o), .EX_ALUSrc_o(EX_ALUSrc_o),
    .EX_Branch_o(EX_Branch_o), .EX_ALUOp_o(EX_ALUOp_o), .EX_PC_o(EX_PC_o),
    .EX_RS1data_o(EX_RS1data_o), .EX_RS2data_o(EX_RS2data_o), .EX_Imm_o(EX_Imm_o),
    .EX_funct_o(EX_funct_o), .EX_rs1_o(EX_rs1_o), .EX_rs2_o(EX_rs2_o), .EX_Rd_o(EX_Rd_o)
  );

  function automatic id_t rand_id();
    id_t v;
    v.valid = 1'($urandom()); v.regwrite = 1'($urandom()); v.memtoreg = 1'($urandom());
    v.memread = 1'($urandom()); v.memwrite = 1'($urandom()); v.alusrc = 1'($urandom());
    v.branch = 1'($urandom()); v.aluop = 2'($urandom());
    v.pc = $urandom(); v.rs1data = $urandom(); v.rs2data = $urandom(); v.imm = $urandom();
    v.funct = 10'($urandom()); v.rs1 = 5'($urandom()); v.rs2 = 5'($urandom()); v.rd = 5'($urandom());
    return v;
  endfunction

  function automatic id_t get_obs();
    id_t v;
    v = {EX_Valid_o, EX_RegWrite_o, EX_MemtoReg_o, EX_MemRead_o, EX_MemWrite_o, EX_ALUSrc_o,
         EX_Branch_o, EX_ALUOp_o, EX_PC_o, EX_RS1data_o, EX_RS2data_o, EX_Imm_o, EX_funct_o,
         EX_rs1_o, EX_rs2_o, EX_Rd_o};
    return v;
  endfunction

  // Keep only the fields a bubble defines (controls and addresses).
  function automatic id_t mask_data(input id_t v);
    id_t m;
    m = v;
    m.pc = 32'd0; m.rs1data = 32'd0; m.rs2data = 32'd0; m.imm = 32'd0; m.funct = 10'd0;
    return m;
  endfunction

  function automatic id_t kill_ctrl(input id_t v);
    id_t m;
    m = v;
    m.valid = 1'b0; m.regwrite = 1'b0; m.memtoreg = 1'b0; m.memread = 1'b0;
    m.memwrite = 1'b0; m.alusrc = 1'b0; m.branch = 1'b0; m.aluop = 2'd0;
    return m;
  endfunction

  task automatic apply_id(input id_t v);
    cur = v;
    {ID_Valid_i, ID_RegWrite_i, ID_MemtoReg_i, ID_MemRead_i, ID_MemWrite_i, ID_ALUSrc_i,
     ID_Branch_i, ID_ALUOp_i, ID_PC_i, ID_RS1data_i, ID_RS2data_i, ID_Imm_i, ID_funct_i,
     ID_rs1_i, ID_rs2_i, ID_Rd_i} = v;
  endtask

  // One clock edge with the given hazard controls; the model follows the rules.
  task automatic cycle(input logic st, input logic bu, input logic fl);
    Stall_i = st; Bubble_i = bu; Flush_i = fl;
    @(posedge clk_i);
    if (!st) begin
      if (bu || fl) begin
        exp_s = kill_ctrl(cur); exp_s.rs1 = 5'd0; exp_s.rs2 = 5'd0; exp_s.rd = 5'd0;
        exp_dc = 1'b1;
      end else begin
        exp_s = cur.valid ? cur : kill_ctrl(cur);
        exp_dc = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    id_t v;
    v = rand_id();
    v.valid = 1'b1; v.regwrite = 1'b1; v.memread = 1'b1; v.aluop = 2'b11; v.rd = 5'd17; v.pc = 32'hDEAD_BEEF;
    apply_id(v);
    Stall_i = 1'b0; Bubble_i = 1'b0; Flush_i = 1'b0;
    rst_i = 1'b1; #1 rst_i = 1'b0; #1;
    exp_s = '0; exp_dc = 1'b0;
    obs = get_obs(); cmp_count++;
    if (obs !== exp_s) begin err_count++; $display("FAIL reset_initial: got %h want 0", obs); end
    #2 rst_i = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    obs = get_obs(); cmp_count++;
    if (obs !== v) begin err_count++; $display("FAIL reset_release_load: got %h want %h", obs, v); end
    #2 rst_i = 1'b0; #1;
    exp_s = '0; exp_dc = 1'b0;
    obs = get_obs(); cmp_count++;
    if (obs !== 162'd0) begin err_count++; $display("FAIL reset_async_clear: got %h want 0", obs); end
    #1 rst_i = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    obs = get_obs(); cmp_count++;
    if (obs !== v) begin err_count++; $display("FAIL reset_reload: got %h want %h", obs, v); end
  endtask

  task automatic test_normal_load();
    id_t v;
    v = rand_id();
    v.valid = 1'b1; v.rs1data = 32'h1234_5678; v.rs1 = 5'd5; v.rd = 5'd7; v.regwrite = 1'b1; v.aluop = 2'b10;
    apply_id(v);
    cycle(1'b0, 1'b0, 1'b0);
    cmp_count++;
    if ({EX_RS1data_o, EX_rs1_o, EX_Rd_o, EX_RegWrite_o, EX_ALUOp_o} !== {32'h1234_5678, 5'd5, 5'd7, 1'b1, 2'b10}) begin
      err_count++;
      $display("FAIL load_directed: got rs1data=%h rs1=%0d rd=%0d rw=%b aluop=%b want 12345678/5/7/1/10",
               EX_RS1data_o, EX_rs1_o, EX_Rd_o, EX_RegWrite_o, EX_ALUOp_o);
    end
    for (int i = 0; i < 20; i++) begin
      v = rand_id(); v.valid = 1'b1;
      apply_id(v);
      cycle(1'b0, 1'b0, 1'b0);
      obs = get_obs(); cmp_count++;
      if (obs !== v) begin err_count++; $display("FAIL load_random[%0d]: got %h want %h", i, obs, v); end
    end
  endtask

  task automatic test_stall();
    id_t v, held;
    v = rand_id(); v.valid = 1'b1; v.rd = 5'd7;
    apply_id(v);
    cycle(1'b0, 1'b0, 1'b0);
    held = v;
    for (int i = 0; i < 3; i++) begin
      v = rand_id(); v.valid = 1'b1; v.rd = 5'd9;
      apply_id(v);
      cycle(1'b1, 1'b0, 1'b0);
      obs = get_obs(); cmp_count++;
      if (EX_Rd_o !== 5'd7 || obs !== held) begin
        err_count++; $display("FAIL stall_hold[%0d]: got %h want %h", i, obs, held);
      end
    end
    cycle(1'b0, 1'b0, 1'b0);
    cmp_count++;
    if (EX_Rd_o !== 5'd9) begin err_count++; $display("FAIL stall_release: got rd=%0d want 9", EX_Rd_o); end
  endtask

  task automatic test_bubble();
    id_t v;
    v = rand_id(); v.valid = 1'b1; v.memread = 1'b1; v.regwrite = 1'b1; v.rd = 5'd3;
    apply_id(v);
    cycle(1'b0, 1'b1, 1'b0);
    cmp_count++;
    if ({EX_RegWrite_o, EX_MemRead_o, EX_Rd_o, EX_Valid_o} !== 8'd0) begin
      err_count++;
      $display("FAIL bubble_zero: got rw=%b mr=%b rd=%0d v=%b want all 0", EX_RegWrite_o, EX_MemRead_o, EX_Rd_o, EX_Valid_o);
    end
    obs = get_obs(); cmp_count++;
    if (mask_data(obs) !== mask_data(exp_s)) begin
      err_count++; $display("FAIL bubble_fields: got %h want %h", mask_data(obs), mask_data(exp_s));
    end
    cycle(1'b0, 1'b0, 1'b0);
    obs = get_obs(); cmp_count++;
    if (obs !== v || EX_Rd_o !== 5'd3 || EX_MemRead_o !== 1'b1) begin
      err_count++; $display("FAIL bubble_then_load: got %h want %h", obs, v);
    end
  endtask

  task automatic test_stall_vs_flush();
    id_t v, held;
    v = rand_id(); v.valid = 1'b1; v.regwrite = 1'b1; v.rd = 5'd21;
    apply_id(v);
    cycle(1'b0, 1'b0, 1'b0);
    held = v;
    v = rand_id(); v.valid = 1'b1;
    apply_id(v);
    cycle(1'b1, 1'b0, 1'b1);
    obs = get_obs(); cmp_count++;
    if (obs !== held) begin err_count++; $display("FAIL stall_over_flush: got %h want %h", obs, held); end
    cycle(1'b0, 1'b0, 1'b1);
    cmp_count++;
    if ({EX_Valid_o, EX_RegWrite_o, EX_MemtoReg_o, EX_MemRead_o, EX_MemWrite_o, EX_ALUSrc_o,
         EX_Branch_o, EX_ALUOp_o, EX_rs1_o, EX_rs2_o, EX_Rd_o} !== 24'd0) begin
      err_count++; $display("FAIL flush_bubble: got ctrl/addr not zero rd=%0d rw=%b", EX_Rd_o, EX_RegWrite_o);
    end
  endtask

  task automatic test_invalid();
    id_t v;
    v = rand_id(); v.valid = 1'b0; v.regwrite = 1'b1; v.memwrite = 1'b1;
    apply_id(v);
    cycle(1'b0, 1'b0, 1'b0);
    cmp_count++;
    if ({EX_RegWrite_o, EX_MemWrite_o, EX_Valid_o} !== 3'b000) begin
      err_count++; $display("FAIL invalid_ctrl: got rw=%b mw=%b v=%b want 000", EX_RegWrite_o, EX_MemWrite_o, EX_Valid_o);
    end
    obs = get_obs(); cmp_count++;
    if (obs !== kill_ctrl(v)) begin err_count++; $display("FAIL invalid_fields: got %h want %h", obs, kill_ctrl(v)); end
  endtask

  task automatic test_reset_mid_stall();
    id_t v;
    v = rand_id(); v.valid = 1'b1; v.rd = 5'd12;
    apply_id(v);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    #2 rst_i = 1'b0; #1;
    exp_s = '0; exp_dc = 1'b0;
    obs = get_obs(); cmp_count++;
    if (obs !== 162'd0) begin err_count++; $display("FAIL reset_in_stall: got %h want 0", obs); end
    #1 rst_i = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    obs = get_obs(); cmp_count++;
    if (obs !== 162'd0) begin err_count++; $display("FAIL stall_after_reset: got %h want 0", obs); end
    cycle(1'b0, 1'b0, 1'b0);
    obs = get_obs(); cmp_count++;
    if (obs !== v) begin err_count++; $display("FAIL load_after_reset_stall: got %h want %h", obs, v); end
  endtask

  task automatic test_random();
    logic st, bu, fl;
    for (int i = 0; i < 300; i++) begin
      apply_id(rand_id());
      st = ($urandom_range(0, 3) == 0);
      bu = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 5) == 0);
      cycle(st, bu, fl);
      obs = get_obs(); cmp_count++;
      if ((exp_dc ? mask_data(obs) : obs) !== (exp_dc ? mask_data(exp_s) : exp_s)) begin
        err_count++; $display("FAIL random[%0d] st=%b bu=%b fl=%b: got %h want %h", i, st, bu, fl, obs, exp_s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal_load();
    test_stall();
    test_bubble();
    test_stall_vs_flush();
    test_invalid();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
